// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding and line constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } uart_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO, registered storage, first-word-fall-through head, count tracked from push/pop.
// A push into a full FIFO is taken only when a pop happens on the same edge; otherwise it is ignored.
module byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  logic                  pop,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push_ok, pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an empty FIFO never exposes its contents.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: 1 clock from push to start bit, no backpressure (full pushes drop, sticky overflow).
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo #(
  parameter int CLK_PER_BIT = 868,
  parameter int DEPTH_LOG2  = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  tx_ready,
  input  logic [7:0]            sdata,
  output logic                  txd,
  output logic                  busy,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   count
);
  import uart_pkg::*;

  localparam int CW     = DEPTH_LOG2 + 1;
  localparam int BAUD_W = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = 1;
  localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);

  uart_state_t state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;
  logic              overflow_q, overflow_d;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  logic          pop, push_ok, bit_end;
  logic [7:0]    fifo_dout;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count, count_nxt;

  byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (tx_ready),
    .pop   (pop),
    .din   (sdata),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    bit_end = (baud_q == BAUD_LAST);

    if (state_q != IDLE) baud_d = bit_end ? '0 : baud_q + BAUD_ONE;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = START;
          txd_d   = 1'b0;
          baud_d  = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          txd_d   = shreg_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            txd_d   = par_q;
`else
            state_d = STOP;
            txd_d   = UART_IDLE_LEVEL;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = shreg_q >> 1;
            txd_d   = shreg_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          txd_d   = UART_IDLE_LEVEL;
        end
      end
      STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit when more bytes are waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = START;
            txd_d   = 1'b0;
          end else begin
            state_d = IDLE;
            txd_d   = UART_IDLE_LEVEL;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = UART_IDLE_LEVEL;
      end
    endcase

    if (pop) shreg_d = fifo_dout;
`ifdef UART_TX_PARITY_EN
    par_d = par_q;
    if (pop) par_d = ^fifo_dout;
`endif

    push_ok    = tx_ready && (!fifo_full || pop);
    count_nxt  = fifo_count + CW'(push_ok) - CW'(pop);
    overflow_d = overflow_q || (tx_ready && fifo_full && !pop);
    busy_d     = (state_d != IDLE) || (count_nxt != '0);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      txd_q      <= UART_IDLE_LEVEL;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign txd      = txd_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign count    = fifo_count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: waveform-queue reference model plus directed literal checks.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DL2   = 2;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk, rstn, tx_ready;
  logic [7:0] sdata;
  logic       txd, busy, overflow;
  logic [DL2:0] count;

  uart_tx_fifo #(.CLK_PER_BIT(CPB), .DEPTH_LOG2(DL2)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .tx_ready (tx_ready),
    .sdata    (sdata),
    .txd      (txd),
    .busy     (busy),
    .overflow (overflow),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending bytes and the remaining per-cycle line levels of the current frame.
  logic [7:0] mq[$];
  logic       line_q[$];
  logic       m_ovf;

  logic       txlog[$];
  logic [7:0] dec[$];
  int         dec_start[$];
  logic       dec_par[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rn, input logic tr, input logic [7:0] d);
    logic       do_pop, accept, dummy;
    logic [7:0] b;
    if (!rn) begin
      mq.delete();
      line_q.delete();
      m_ovf = 1'b0;
      return;
    end
    if (line_q.size() > 0) dummy = line_q.pop_front();
    do_pop = (line_q.size() == 0) && (mq.size() > 0);
    accept = tr && ((mq.size() < DEPTH) || do_pop);
    if (tr && !accept) m_ovf = 1'b1;
    if (do_pop) begin
      b = mq.pop_front();
      for (int i = 0; i < CPB; i++) line_q.push_back(1'b0);
      for (int k = 0; k < 8; k++)
        for (int i = 0; i < CPB; i++) line_q.push_back(b[k]);
`ifdef UART_TX_PARITY_EN
      for (int i = 0; i < CPB; i++) line_q.push_back(^b);
`endif
      for (int i = 0; i < CPB; i++) line_q.push_back(1'b1);
    end
    if (accept) mq.push_back(d);
  endtask

  task automatic step(input logic rn, input logic tr, input logic [7:0] d);
    logic exp_txd;
    rstn = rn; tx_ready = tr; sdata = d;
    @(posedge clk);
    model_edge(rn, tr, d);
    @(negedge clk);
    txlog.push_back(txd);
    exp_txd = (line_q.size() > 0) ? line_q[0] : 1'b1;
    chk("txd", txd, exp_txd);
    chk("busy", busy, (line_q.size() > 0) || (mq.size() > 0));
    chk("overflow", overflow, m_ovf);
    chk("count", count, mq.size());
  endtask

  task automatic decode();
    int i;
    logic [7:0] b;
    dec.delete(); dec_start.delete(); dec_par.delete();
    i = 0;
    while (i + FRAME <= txlog.size()) begin
      if (txlog[i] == 1'b0) begin
        for (int k = 0; k < 8; k++) b[k] = txlog[i + CPB*(k+1) + CPB/2];
        dec.push_back(b);
        dec_start.push_back(i);
        dec_par.push_back(txlog[i + CPB*9 + CPB/2]);
        i += FRAME;
      end else begin
        i++;
      end
    end
  endtask

  initial begin
    logic [10:0] pat;
    int peak, zeros, gap_lit;
    logic rn, tr;

    m_ovf = 1'b0;
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("reset_txd", txd, 1);
    chk("reset_busy", busy, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_count", count, 0);

    // Single byte 0x55: start, LSB-first data, (parity), stop.
`ifdef UART_TX_PARITY_EN
    pat = 11'b10010101010;
`else
    pat = 11'b01010101010;
`endif
    step(1'b1, 1'b1, 8'h55);
    chk("t1_push_busy", busy, 1);
    chk("t1_push_txd", txd, 1);
    for (int k = 1; k <= FRAME; k++) begin
      step(1'b1, 1'b0, 8'($urandom));
      chk("t1_txd_bit", txd, pat[(k-1)/CPB]);
      chk("t1_busy_hold", busy, 1);
    end
    step(1'b1, 1'b0, 8'h00);
    chk("t1_busy_fall", busy, 0);
    chk("t1_idle_txd", txd, 1);

    // Back-to-back bytes: no gap between frames.
    txlog.delete();
    peak = 0;
    step(1'b1, 1'b1, 8'hA3);
    if (int'(count) > peak) peak = int'(count);
    step(1'b1, 1'b1, 8'h0F);
    for (int k = 0; k < 2*FRAME + 4; k++) begin
      if (int'(count) > peak) peak = int'(count);
      step(1'b1, 1'b0, 8'($urandom));
    end
    decode();
`ifdef UART_TX_PARITY_EN
    gap_lit = 44;
`else
    gap_lit = 40;
`endif
    chk("b2b_nframes", dec.size(), 2);
    chk("b2b_peak_count", peak, 1);
    if (dec.size() >= 2) begin
      chk("b2b_byte0", dec[0], 8'hA3);
      chk("b2b_byte1", dec[1], 8'h0F);
      chk("b2b_gap", dec_start[1] - dec_start[0], gap_lit);
    end

    // Overflow: six pushes into a 4-deep FIFO while the first byte is on the line.
    txlog.delete();
    for (int v = 1; v <= 5; v++) step(1'b1, 1'b1, 8'(v));
    chk("ovf_before", overflow, 0);
    chk("ovf_full_count", count, 4);
    step(1'b1, 1'b1, 8'h06);
    chk("ovf_set", overflow, 1);
    chk("ovf_count_after_drop", count, 4);
    for (int k = 0; k < 5*FRAME + 8; k++) step(1'b1, 1'b0, 8'($urandom));
    decode();
    chk("ovf_nframes", dec.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < dec.size()) chk("ovf_byte", dec[i], i + 1);
    chk("ovf_sticky", overflow, 1);

    // Reset during data bit 3 of 0xFF.
    txlog.delete();
    step(1'b1, 1'b1, 8'hFF);
    for (int k = 1; k <= 18; k++) step(1'b1, 1'b0, 8'h00);
    chk("rst_mid_busy_before", busy, 1);
    step(1'b0, 1'b0, 8'h00);
    chk("rst_mid_txd", txd, 1);
    chk("rst_mid_count", count, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_overflow", overflow, 0);
    txlog.delete();
    for (int k = 0; k < 2*FRAME; k++) step(1'b1, 1'b0, 8'h00);
    zeros = 0;
    foreach (txlog[i]) if (txlog[i] == 1'b0) zeros++;
    chk("rst_mid_no_frame", zeros, 0);

`ifdef UART_TX_PARITY_EN
    // Even parity bits and 11-bit frame length.
    txlog.delete();
    step(1'b1, 1'b1, 8'h07);
    step(1'b1, 1'b1, 8'h03);
    for (int k = 0; k < 2*FRAME + 4; k++) step(1'b1, 1'b0, 8'h00);
    decode();
    chk("par_nframes", dec.size(), 2);
    if (dec.size() >= 2) begin
      chk("par_bit_07", dec_par[0], 1);
      chk("par_bit_03", dec_par[1], 0);
      chk("par_frame_len", dec_start[1] - dec_start[0], 44);
    end
`endif

    // Idle with sdata toggling.
    for (int k = 0; k < 1000; k++) begin
      step(1'b1, 1'b0, (k % 2 == 0) ? 8'hFF : 8'h00);
      chk("idle_txd", txd, 1);
      chk("idle_count", count, 0);
    end

    // Random traffic: alternating sparse and bursty phases, rare resets.
    for (int n = 0; n < 6000; n++) begin
      rn = ($urandom_range(0, 499) != 0);
      if (((n / 500) % 2) == 1) tr = ($urandom_range(0, 3) != 0);
      else                      tr = ($urandom_range(0, 40) == 0);
      step(rn, tr, 8'($urandom));
    end
    for (int k = 0; k < (DEPTH + 2) * FRAME; k++) step(1'b1, 1'b0, 8'($urandom));
    chk("final_busy", busy, 0);
    chk("final_txd", txd, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
